// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory-stage load/store unit and its helpers.
package mem_access_pkg;

    // Funct3 access size/sign encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte-enable patterns before shifting by the address offset
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } stateT;

    // Stores only come in signed sizes; loads also allow the unsigned forms.
    function automatic logic funct3Legal(input logic [2:0] funct3, input logic isStore);
        logic legal;
        legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        if (!isStore) begin
            legal = legal || (funct3 == F3_BU) || (funct3 == F3_HU);
        end
        return legal;
    endfunction

endpackage

// File: rtl/load_align.sv
// Moves the addressed byte/halfword of a bus word down to bit 0 and
// sign- or zero-extends it according to the load type.
module load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] formatted
);

    logic [31:0] lane;

    // Lane select followed by extension; unknown encodings yield zero.
    always_comb begin
        lane = rdata >> {offset, 3'b000};
        case (funct3)
            F3_B:    formatted = {{24{lane[7]}}, lane[7:0]};
            F3_H:    formatted = {{16{lane[15]}}, lane[15:0]};
            F3_W:    formatted = rdata;
            F3_BU:   formatted = {24'd0, lane[7:0]};
            F3_HU:   formatted = {16'd0, lane[15:0]};
            default: formatted = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage load/store unit: single-outstanding request/ready bus master
// that stalls the pipeline while an access is in flight.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    stateT            state;
    stateT            stateNext;
    logic [CNT_W-1:0] waitCount;
    logic [1:0]       offset;
    logic             isAccess;
    logic             isStore;
    logic             isFault;
    logic             startAccess;
    logic             timedOut;
    logic [3:0]       beNext;
    logic [31:0]      wdataNext;
    logic [2:0]       funct3Q;
    logic [1:0]       offsetQ;
    logic [31:0]      resultQ;
    logic [31:0]      loadData;

    assign offset = ALUResultM[1:0];

    // Classify the M-stage instruction and detect illegal or misaligned accesses.
    always_comb begin
        // NOTE: every variable gets a value before any branch so no latch is inferred.
        isAccess = MemReadM | MemWriteM;
        isStore  = MemWriteM;
        isFault  = 1'b0;
        if (isAccess) begin
            if (!funct3Legal(Funct3M, isStore)) begin
                isFault = 1'b1;
            end else if ((Funct3M[1:0] == 2'b01) && offset[0]) begin
                isFault = 1'b1;
            end else if ((Funct3M[1:0] == 2'b10) && (offset != 2'b00)) begin
                isFault = 1'b1;
            end
        end
    end

    assign startAccess = (state == IDLE) && isAccess && !isFault;
    assign timedOut    = (state == BUSY) && !bus_ready && (waitCount == CNT_LAST);

    // Byte enables and lane-replicated store data for the requested size.
    always_comb begin
        case (Funct3M[1:0])
            2'b00: begin
                beNext    = BE_BYTE << offset;
                wdataNext = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                beNext    = BE_HALF << offset;
                wdataNext = {2{WriteDataM[15:0]}};
            end
            default: begin
                beNext    = BE_WORD;
                wdataNext = WriteDataM;
            end
        endcase
    end

    // Next-state logic; ready in the last allowed cycle beats the timeout.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (startAccess) stateNext = BUSY;
            BUSY:    if (bus_ready || timedOut) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    // Cycles spent waiting in BUSY; cleared whenever the access finishes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waitCount <= '0;
        end else if ((state == BUSY) && !bus_ready && !timedOut) begin
            waitCount <= waitCount + CNT_W'(1);
        end else begin
            waitCount <= '0;
        end
    end

    // Request valid is high exactly while the FSM sits in BUSY.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) bus_req <= 1'b0;
        else        bus_req <= (stateNext == BUSY);
    end

    // Capture the access when it is accepted so the bus sees stable values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            funct3Q   <= '0;
            offsetQ   <= '0;
        end else if (startAccess) begin
            bus_we    <= isStore;
            bus_addr  <= {ALUResultM[31:2], 2'b00};
            bus_be    <= beNext;
            bus_wdata <= wdataNext;
            funct3Q   <= Funct3M;
            offsetQ   <= offset;
        end
    end

    load_align uLoadAlign (
        .rdata     (bus_rdata),
        .offset    (offsetQ),
        .funct3    (funct3Q),
        .formatted (loadData)
    );

    // Result register: formatted load data, or zero for stores and timeouts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resultQ <= '0;
        end else if ((state == BUSY) && bus_ready) begin
            resultQ <= bus_we ? 32'd0 : loadData;
        end else if (timedOut) begin
            resultQ <= '0;
        end
    end

    // Pipeline-facing outputs; reset gating makes the stall drop immediately.
    assign StallM    = reset & (startAccess | (state == BUSY));
    assign MisalignM = reset & (state == IDLE) & isAccess & isFault;
    assign BusErrM   = timedOut;
    assign ReadDataM = (state == DONE) ? resultQ : 32'd0;

endmodule
